sw_onehot_encoder: RTL

//  Parametrised, registered one-hot-to-binary encoder for board switches.
//  - Synchronises and debounces an N-bit switch bus, then encodes it into a

---
 rtl/sw_enc_pkg.sv | 14 +
 rtl/sw_debounce.sv | 47 ++++
 rtl/sw_onehot_encoder.sv | 124 ++++++++++++
 3 files changed

// File: rtl/sw_enc_pkg.sv
// Shared types and constants for the switch one-hot encoder family.
// State encoding classifies the debounced switch bus by how many bits are set.
package sw_enc_pkg;

    typedef enum logic [1:0] {
        ST_NONE  = 2'd0,
        ST_ONE   = 2'd1,
        ST_MULTI = 2'd2
    } sw_state_e;

    localparam int MODE_STRICT = 0;
    localparam int MODE_PRIO   = 1;

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser plus per-bus debouncer: a new switch pattern must hold
// for DEBOUNCE consecutive cycles after synchronisation before it reaches stable.
module sw_debounce #(
    parameter int N        = 4,
    parameter int DEBOUNCE = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] sw,
    output logic [N-1:0] stable
);

    localparam int            CW       = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [N-1:0]  sync1_r;
    logic [N-1:0]  sync2_r;
    logic [N-1:0]  cand_r;
    logic [N-1:0]  stable_r;
    logic [CW-1:0] cnt_r;

    // Synchronise, then restart the count on any change and accept once stable long enough.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r  <= {N{1'b0}};
            sync2_r  <= {N{1'b0}};
            cand_r   <= {N{1'b0}};
            stable_r <= {N{1'b0}};
            cnt_r    <= {CW{1'b0}};
        end else begin
            sync1_r <= sw;
            sync2_r <= sync1_r;
            if (sync2_r != cand_r) begin
                cand_r <= sync2_r;
                cnt_r  <= {CW{1'b0}};
            end else if (cnt_r == CNT_LAST) begin
                stable_r <= cand_r;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

    assign stable = stable_r;

endmodule

// File: rtl/sw_onehot_encoder.sv
// Registered one-hot (or priority) to binary encoder for debounced board switches,
// with valid, multi-hot error and one-cycle change flags.
module sw_onehot_encoder
    import sw_enc_pkg::*;
#(
    parameter int N        = 4,
    parameter int DEBOUNCE = 4,
    parameter int MODE     = 0,
    localparam int W       = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] sw,
    output logic [W-1:0] code,
    output logic         valid,
    output logic         err,
    output logic         chg
);

    logic [N-1:0] stable_s;
    logic         none_s;
    logic         multi_s;
    logic [W-1:0] hi_idx_s;
    sw_state_e    state_r;
    sw_state_e    state_next_s;
    logic [W-1:0] code_r;
    logic [W-1:0] code_next_s;
    logic         valid_r;
    logic         valid_next_s;
    logic         prev_valid_s;
    logic         err_r;
    logic         err_next_s;
    logic         chg_r;
    logic         chg_next_s;

    sw_debounce #(
        .N        (N),
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .clk    (clk),
        .rst    (rst),
        .sw     (sw),
        .stable (stable_s)
    );

    // Clearing the lowest set bit leaves something only when two or more bits are set.
    assign none_s  = (stable_s == {N{1'b0}});
    assign multi_s = |(stable_s & (stable_s - N'(1)));

    // Highest set bit index; for a one-hot input this is simply its position.
    always_comb begin
        hi_idx_s = {W{1'b0}};
        for (int i = 0; i < N; i++) begin
            hi_idx_s = stable_s[i] ? W'(i) : hi_idx_s;
        end
    end

    // Next-state classification of the stable bus.
    always_comb begin
        state_next_s = ST_NONE;
        if (none_s) begin
            state_next_s = ST_NONE;
        end else if (multi_s) begin
            state_next_s = ST_MULTI;
        end else begin
            state_next_s = ST_ONE;
        end
    end

    // Output values decoded from the next state, plus change detection.
    always_comb begin
        code_next_s  = code_r;
        valid_next_s = 1'b0;
        err_next_s   = 1'b0;
        prev_valid_s = (state_r == ST_ONE) ||
                       ((state_r == ST_MULTI) && (MODE == MODE_PRIO));
        case (state_next_s)
            ST_NONE: begin
                valid_next_s = 1'b0;
            end
            ST_ONE: begin
                valid_next_s = 1'b1;
                code_next_s  = hi_idx_s;
            end
            ST_MULTI: begin
                err_next_s = 1'b1;
                if (MODE == MODE_PRIO) begin
                    valid_next_s = 1'b1;
                    code_next_s  = hi_idx_s;
                end else begin
                    valid_next_s = 1'b0;
                end
            end
            default: begin
                valid_next_s = 1'b0;
                err_next_s   = 1'b0;
            end
        endcase
        chg_next_s = (code_next_s != code_r) || (valid_next_s && !prev_valid_s);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_NONE;
            code_r  <= {W{1'b0}};
            valid_r <= 1'b0;
            err_r   <= 1'b0;
            chg_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            code_r  <= code_next_s;
            valid_r <= valid_next_s;
            err_r   <= err_next_s;
            chg_r   <= chg_next_s;
        end
    end

    assign code  = code_r;
    assign valid = valid_r;
    assign err   = err_r;
    assign chg   = chg_r;

endmodule
